// File: rtl/multiciclo_control_hs.sv
// Multicycle control FSM for the RV32I multicycle datapath, with handshaking.
// It drives every datapath select and write enable from opcode, funct3 and zero.
// The shared memory completes a transfer only in a cycle where mem_ready is high.
// An optional memory watchdog moves the FSM to HALT. A fault code is latched.
// A count of retired instructions is kept.
//
// State table (state | meaning):
//   0  FETCH    | read IR from mem[PC], PC <= PC+4, CurPC <= PC
//   1  DECODE   | branch target CurPC+imm -> ALURegister, dispatch on opcode
//   2  EXEC_R   | reg op reg
//   3  EXEC_I   | reg op imm
//   4  MEM_ADDR | effective address reg+imm
//   5  MEM_RD   | load data read, waits for mem_ready
//   6  MEM_WR   | store write, waits for mem_ready
//   7  WB_ALU   | rd <= ALURegister
//   8  WB_MEM   | rd <= DataRegister
//   9  BRANCH   | compare, conditional PC <= ALURegister
//   10 JAL      | rd <= PC, PC <= ALURegister
//   11 JALR     | rd <= PC, PC <= reg+imm
//   12 LUI      | pass immediate
//   13 HALT     | stopped, exits only through reset
//
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   opcode, funct3, zero    IR fields and the ALU zero flag
//   mem_ready               the memory completes its current access this cycle
//   mem_*, ir_write, ...    datapath controls (enables are forced low during reset)
//   halted, fault, state    status and debug outputs
//   retired                 count of retired instructions, wraps around
module multiciclo_control_hs #(
  parameter int CNT_W           = 32,
  parameter int MEM_TIMEOUT     = 0,
  parameter int TO_W            = 8,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_addr_sel,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             cur_pc_write,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             reg_write,
  output logic [1:0]       reg_in_sel,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;

  localparam int              TO_LIM_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TO_LIM_I);

  logic [3:0]       state_q, state_d;
  logic [1:0]       fault_q, fault_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [TO_W-1:0]  wd_q, wd_d;

  logic mem_read_r, mem_write_r, ir_write_r, cur_pc_write_r, pc_write_r, reg_write_r;
  logic taken, retire, waiting;

  always_comb begin
    state_d        = state_q;
    fault_d        = fault_q;
    retire         = 1'b0;
    mem_addr_sel   = 1'b0;
    mem_read_r     = 1'b0;
    mem_write_r    = 1'b0;
    ir_write_r     = 1'b0;
    cur_pc_write_r = 1'b0;
    pc_write_r     = 1'b0;
    pc_sel         = 1'b0;
    reg_write_r    = 1'b0;
    reg_in_sel     = 2'd0;
    alu_a_sel      = 2'd0;
    alu_b_sel      = 2'd0;
    alu_op         = 2'd0;
    taken          = zero ^ funct3[0] ^ funct3[2];
    case (state_q)
      S_FETCH: begin
        mem_read_r = 1'b1;
        alu_a_sel  = 2'd1;
        alu_b_sel  = 2'd1;
        if (mem_ready) begin
          ir_write_r     = 1'b1;
          pc_write_r     = 1'b1;
          cur_pc_write_r = 1'b1;
          state_d        = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_a_sel = 2'd0;
        alu_b_sel = 2'd2;
        case (opcode)
          7'b0110011:             state_d = S_EXEC_R;
          7'b0010011:             state_d = S_EXEC_I;
          7'b0000011, 7'b0100011: state_d = S_MEM_ADDR;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_WB_ALU;
          7'b1110011: begin
            state_d = S_HALT;
            fault_d = 2'd3;
          end
          default: begin
            // Without halting, an illegal opcode is dropped as an uncounted NOP.
            if (HALT_ON_ILLEGAL) begin
              state_d = S_HALT;
              fault_d = 2'd1;
            end else begin
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_EXEC_R: begin
        alu_a_sel = 2'd2;
        alu_b_sel = 2'd0;
        alu_op    = 2'd2;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_a_sel = 2'd2;
        alu_b_sel = 2'd2;
        alu_op    = 2'd2;
        state_d   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_a_sel = 2'd2;
        alu_b_sel = 2'd2;
        state_d   = (opcode == 7'b0000011) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read_r   = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_write_r  = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_ALU: begin
        reg_write_r = 1'b1;
        reg_in_sel  = 2'd0;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_r = 1'b1;
        reg_in_sel  = 2'd2;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_BRANCH: begin
        alu_a_sel  = 2'd2;
        alu_b_sel  = 2'd0;
        alu_op     = funct3[2] ? 2'd2 : 2'd1;
        pc_sel     = 1'b1;
        // funct3 010/011 are not branches: they retire without redirecting the PC.
        pc_write_r = taken & ~(funct3[2:1] == 2'b01);
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_JAL: begin
        reg_write_r = 1'b1;
        reg_in_sel  = 2'd1;
        pc_write_r  = 1'b1;
        pc_sel      = 1'b1;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_JALR: begin
        alu_a_sel   = 2'd2;
        alu_b_sel   = 2'd2;
        pc_sel      = 1'b0;
        pc_write_r  = 1'b1;
        reg_write_r = 1'b1;
        reg_in_sel  = 2'd1;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_LUI: begin
        alu_b_sel = 2'd2;
        alu_op    = 2'd3;
        state_d   = S_WB_ALU;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
        fault_d = 2'd1;
      end
    endcase

    // The watchdog counts only stalled memory cycles. When mem_ready is high
    // the counter clears, so a completing access always beats a timeout.
    waiting = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR)) && !mem_ready;
    wd_d    = '0;
    if (waiting) begin
      wd_d = wd_q + TO_W'(1);
      if ((MEM_TIMEOUT != 0) && (wd_q == TO_LIM)) begin
        state_d = S_HALT;
        fault_d = 2'd2;
        wd_d    = '0;
      end
    end

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      fault_q   <= 2'd0;
      retired_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      wd_q      <= wd_d;
    end
  end

  // Reset also masks the requests and enables at once, not only at the next edge.
  assign mem_read     = mem_read_r & reset_n;
  assign mem_write    = mem_write_r & reset_n;
  assign ir_write     = ir_write_r & reset_n;
  assign cur_pc_write = cur_pc_write_r & reset_n;
  assign pc_write     = pc_write_r & reset_n;
  assign reg_write    = reg_write_r & reset_n;
  assign halted       = (state_q == S_HALT);
  assign fault        = fault_q;
  assign state        = state_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_multiciclo_control_hs.sv
module tb_multiciclo_control_hs;

  logic       clock = 1'b0;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;

  // Instance A: watchdog disabled, an illegal opcode halts the FSM.
  logic        a_rst_n, a_ready;
  logic        a_addr_sel, a_mrd, a_mwr, a_irw, a_cpw, a_pcw, a_pcsel, a_rw, a_halted;
  logic [1:0]  a_rin, a_asel, a_bsel, a_op, a_fault;
  logic [3:0]  a_state;
  logic [31:0] a_retired;

  // Instance B: MEM_TIMEOUT=4, an illegal opcode is treated as a NOP.
  logic        b_rst_n, b_ready;
  logic        b_addr_sel, b_mrd, b_mwr, b_irw, b_cpw, b_pcw, b_pcsel, b_rw, b_halted;
  logic [1:0]  b_rin, b_asel, b_bsel, b_op, b_fault;
  logic [3:0]  b_state;
  logic [31:0] b_retired;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  multiciclo_control_hs #(.CNT_W(32), .MEM_TIMEOUT(0), .TO_W(8), .HALT_ON_ILLEGAL(1'b1)) dut_a (
    .clock(clock), .reset_n(a_rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(a_ready), .mem_addr_sel(a_addr_sel), .mem_read(a_mrd), .mem_write(a_mwr),
    .ir_write(a_irw), .cur_pc_write(a_cpw), .pc_write(a_pcw), .pc_sel(a_pcsel),
    .reg_write(a_rw), .reg_in_sel(a_rin), .alu_a_sel(a_asel), .alu_b_sel(a_bsel),
    .alu_op(a_op), .halted(a_halted), .fault(a_fault), .state(a_state), .retired(a_retired)
  );

  multiciclo_control_hs #(.CNT_W(32), .MEM_TIMEOUT(4), .TO_W(8), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clock(clock), .reset_n(b_rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(b_ready), .mem_addr_sel(b_addr_sel), .mem_read(b_mrd), .mem_write(b_mwr),
    .ir_write(b_irw), .cur_pc_write(b_cpw), .pc_write(b_pcw), .pc_sel(b_pcsel),
    .reg_write(b_rw), .reg_in_sel(b_rin), .alu_a_sel(b_asel), .alu_b_sel(b_bsel),
    .alu_op(b_op), .halted(b_halted), .fault(b_fault), .state(b_state), .retired(b_retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    a_rst_n = 1'b0; a_ready = 1'b1;
    b_rst_n = 1'b0; b_ready = 1'b0;
    opcode  = 7'b0010011; funct3 = 3'b000; zero = 1'b0;
    #1;
    chk("rst_state", {28'd0, a_state}, 32'd0);
    chk("rst_retired", a_retired, 32'd0);
    chk("rst_fault", {30'd0, a_fault}, 32'd0);
    chk("rst_mem_read_forced", {31'd0, a_mrd}, 32'd0);
    tick(); tick();
    a_rst_n = 1'b1; #1;

    // addi x1,x0,5: states 0,1,3,7,0
    chk("addi_fetch_irw", {31'd0, a_irw}, 32'd1);
    chk("addi_fetch_pcw", {31'd0, a_pcw}, 32'd1);
    chk("addi_fetch_cpw", {31'd0, a_cpw}, 32'd1);
    chk("addi_fetch_mrd", {31'd0, a_mrd}, 32'd1);
    chk("addi_fetch_asel", {30'd0, a_asel}, 32'd1);
    chk("addi_fetch_bsel", {30'd0, a_bsel}, 32'd1);
    tick(); chk("addi_s1", {28'd0, a_state}, 32'd1);
    chk("addi_decode_bsel", {30'd0, a_bsel}, 32'd2);
    tick(); chk("addi_s3", {28'd0, a_state}, 32'd3);
    chk("addi_exec_op", {30'd0, a_op}, 32'd2);
    chk("addi_exec_rw", {31'd0, a_rw}, 32'd0);
    tick(); chk("addi_s7", {28'd0, a_state}, 32'd7);
    chk("addi_wb_rw", {31'd0, a_rw}, 32'd1);
    chk("addi_wb_ret", a_retired, 32'd0);
    tick(); chk("addi_s0", {28'd0, a_state}, 32'd0);
    chk("addi_ret", a_retired, 32'd1);

    // lw with mem_ready low while in MEM_RD
    opcode = 7'b0000011; #1;
    tick(); chk("lw_s1", {28'd0, a_state}, 32'd1);
    tick(); chk("lw_s4", {28'd0, a_state}, 32'd4);
    a_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lw_wait_state", {28'd0, a_state}, 32'd5);
      chk("lw_wait_rw", {31'd0, a_rw}, 32'd0);
      chk("lw_wait_mrd", {31'd0, a_mrd}, 32'd1);
    end
    chk("lw_addr_sel", {31'd0, a_addr_sel}, 32'd1);
    a_ready = 1'b1;
    tick(); chk("lw_s8", {28'd0, a_state}, 32'd8);
    chk("lw_wb_rin", {30'd0, a_rin}, 32'd2);
    chk("lw_wb_rw", {31'd0, a_rw}, 32'd1);
    tick(); chk("lw_ret", a_retired, 32'd2);

    // beq zero=1 (taken)
    opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1; #1;
    tick(); tick();
    chk("beq_s9", {28'd0, a_state}, 32'd9);
    chk("beq_pcw", {31'd0, a_pcw}, 32'd1);
    chk("beq_op", {30'd0, a_op}, 32'd1);
    chk("beq_pcsel", {31'd0, a_pcsel}, 32'd1);
    tick(); chk("beq_ret", a_retired, 32'd3);
    // bne zero=1 (not taken)
    funct3 = 3'b001; #1;
    tick(); tick();
    chk("bne_pcw", {31'd0, a_pcw}, 32'd0);
    tick(); chk("bne_ret", a_retired, 32'd4);
    // blt zero=0 (taken)
    funct3 = 3'b100; zero = 1'b0; #1;
    tick(); tick();
    chk("blt_pcw", {31'd0, a_pcw}, 32'd1);
    chk("blt_op", {30'd0, a_op}, 32'd2);
    tick(); chk("blt_ret", a_retired, 32'd5);

    // JAL
    opcode = 7'b1101111; funct3 = 3'b000; #1;
    tick(); tick();
    chk("jal_s10", {28'd0, a_state}, 32'd10);
    chk("jal_rw", {31'd0, a_rw}, 32'd1);
    chk("jal_rin", {30'd0, a_rin}, 32'd1);
    chk("jal_pcw", {31'd0, a_pcw}, 32'd1);
    tick(); chk("jal_ret", a_retired, 32'd6);

    // store, then reset pulsed in MEM_WR
    opcode = 7'b0100011; #1;
    tick(); tick(); tick();
    chk("sw_s6", {28'd0, a_state}, 32'd6);
    chk("sw_mwr", {31'd0, a_mwr}, 32'd1);
    a_rst_n = 1'b0; #1;
    chk("rstmid_state", {28'd0, a_state}, 32'd0);
    chk("rstmid_mwr", {31'd0, a_mwr}, 32'd0);
    chk("rstmid_ret", a_retired, 32'd0);
    chk("rstmid_fault", {30'd0, a_fault}, 32'd0);
    tick(); a_rst_n = 1'b1; #1;

    // illegal opcode halts with fault=1
    opcode = 7'b1111111; #1;
    tick(); tick();
    chk("ill_s13", {28'd0, a_state}, 32'd13);
    chk("ill_fault", {30'd0, a_fault}, 32'd1);
    chk("ill_halted", {31'd0, a_halted}, 32'd1);
    tick(); tick();
    chk("ill_stays", {28'd0, a_state}, 32'd13);
    chk("ill_no_mrd", {31'd0, a_mrd}, 32'd0);
    chk("ill_ret", a_retired, 32'd0);
    a_rst_n = 1'b0; #1; tick(); a_rst_n = 1'b1; #1;

    // ECALL halts with fault=3
    opcode = 7'b1110011; #1;
    tick(); tick();
    chk("ecall_s13", {28'd0, a_state}, 32'd13);
    chk("ecall_fault", {30'd0, a_fault}, 32'd3);

    // Watchdog on instance B: mem_ready held low in FETCH
    b_rst_n = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_wait_state", {28'd0, b_state}, 32'd0);
      chk("wd_wait_irw", {31'd0, b_irw}, 32'd0);
    end
    tick();
    chk("wd_halt_state", {28'd0, b_state}, 32'd13);
    chk("wd_fault", {30'd0, b_fault}, 32'd2);
    chk("wd_halted", {31'd0, b_halted}, 32'd1);
    chk("wd_ret", b_retired, 32'd0);

    // mem_ready arriving in the last allowed cycle wins over the timeout
    b_rst_n = 1'b0; #1; tick(); b_rst_n = 1'b1;
    opcode = 7'b1111111; #1;
    tick(); tick(); tick();
    b_ready = 1'b1; #1;
    tick();
    chk("wd_ready_wins", {28'd0, b_state}, 32'd1);
    chk("wd_ready_fault", {30'd0, b_fault}, 32'd0);
    // the illegal opcode becomes an uncounted NOP
    tick();
    chk("nop_state", {28'd0, b_state}, 32'd0);
    chk("nop_ret", b_retired, 32'd0);
    chk("nop_fault", {30'd0, b_fault}, 32'd0);
    opcode = 7'b0010011; #1;
    tick(); tick(); tick(); tick();
    chk("b_addi_ret", b_retired, 32'd1);
    chk("b_addi_state", {28'd0, b_state}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
